// File: rtl/warp_arbiter.sv
// warp_arbiter: round-robin time-slicing of one core datapath among resident warps with per-warp PC contexts
module warp_arbiter #(
  parameter int NUM_WARPS = 4,
  parameter int PC_BITS   = 8,
  parameter int MIN_RUN   = 2,
  parameter int WID_BITS  = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WID_BITS:0]    warp_count,
  input  logic                 stall,
  input  logic                 ret,
  input  logic                 pc_update_valid,
  input  logic [PC_BITS-1:0]   pc_update,
  output logic [NUM_WARPS-1:0] grant,
  output logic                 grant_valid,
  output logic [WID_BITS-1:0]  warp_id,
  output logic [PC_BITS-1:0]   current_pc,
  output logic                 switch_pulse,
  output logic                 done
);
  localparam int RUN_BITS = $clog2(MIN_RUN + 1);
  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_RUN, S_DONE} state_t;
  state_t state, next_state;
  logic [PC_BITS-1:0]   pcs [NUM_WARPS];
  logic [NUM_WARPS-1:0] done_bits;
  logic [WID_BITS-1:0]  rr, sel, cand, after_w;
  logic [RUN_BITS-1:0]  run;
  logic others, run_ok, do_switch;
  assign others    = |(~done_bits & ~grant);
  assign run_ok    = run >= RUN_BITS'(MIN_RUN);
  assign do_switch = stall && run_ok && others;
  assign after_w   = (int'(warp_id) == NUM_WARPS - 1) ? '0 : warp_id + WID_BITS'(1);
  // first not-done warp scanning from rr upward with wrap; the lowest offset wins
  always_comb begin
    sel  = rr;
    cand = rr;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      cand = WID_BITS'((int'(rr) + k) % NUM_WARPS);
      if (!done_bits[cand]) sel = cand;
    end
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= next_state;
  end
  // next-state logic; ret outranks stall
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = start ? ((warp_count == '0) ? S_DONE : S_SELECT) : S_IDLE;
      S_SELECT: next_state = S_RUN;
      S_RUN:    next_state = ret ? (others ? S_SELECT : S_DONE) : (do_switch ? S_SELECT : S_RUN);
      default:  next_state = start ? S_DONE : S_IDLE;
    endcase
  end
  // registered outputs and warp contexts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant        <= '0;
      grant_valid  <= 1'b0;
      warp_id      <= '0;
      current_pc   <= '0;
      switch_pulse <= 1'b0;
      done         <= 1'b0;
      done_bits    <= '0;
      rr           <= '0;
      run          <= '0;
      for (int i = 0; i < NUM_WARPS; i++) pcs[i] <= '0;
    end else begin
      switch_pulse <= 1'b0;
      done         <= next_state == S_DONE;
      case (state)
        S_IDLE: if (start && warp_count != '0) begin
          rr <= '0;
          for (int i = 0; i < NUM_WARPS; i++) begin
            pcs[i]       <= '0;
            done_bits[i] <= i >= int'(warp_count);
          end
        end
        S_SELECT: begin
          grant_valid <= 1'b1;
          grant       <= NUM_WARPS'(1) << sel;
          warp_id     <= sel;
          current_pc  <= pcs[sel];
          run         <= RUN_BITS'(1);
        end
        S_RUN: if (ret) begin
          done_bits[warp_id] <= 1'b1;
          grant_valid        <= 1'b0;
          grant              <= '0;
          rr                 <= after_w;
          if (pc_update_valid) pcs[warp_id] <= pc_update;
        end else if (do_switch) begin
          grant_valid  <= 1'b0;
          grant        <= '0;
          switch_pulse <= 1'b1;
          rr           <= after_w;
        end else begin
          if (!run_ok) run <= run + RUN_BITS'(1);
          if (pc_update_valid) begin
            pcs[warp_id] <= pc_update;
            current_pc   <= pc_update;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_warp_arbiter.sv
// tb_warp_arbiter: directed checks of launch, round-robin switching, PC contexts, retirement and edge cases
module tb_warp_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] warp_count = 3'd4;
  logic       stall = 1'b0;
  logic       ret = 1'b0;
  logic       pc_update_valid = 1'b0;
  logic [7:0] pc_update = 8'h00;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] warp_id;
  logic [7:0] current_pc;
  logic       switch_pulse;
  logic       done;
  int checks = 0;
  int failures = 0;

  warp_arbiter dut (
    .clk(clk), .reset(reset), .start(start), .warp_count(warp_count),
    .stall(stall), .ret(ret), .pc_update_valid(pc_update_valid), .pc_update(pc_update),
    .grant(grant), .grant_valid(grant_valid), .warp_id(warp_id), .current_pc(current_pc),
    .switch_pulse(switch_pulse), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] w, input logic [7:0] pc);
    chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
    chk({tag, "_grant"}, 32'(grant), 32'(4'b0001 << w));
    chk({tag, "_id"}, 32'(warp_id), 32'(w));
    chk({tag, "_pc"}, 32'(current_pc), 32'(pc));
  endtask

  task automatic chk_switch(input string tag);
    chk({tag, "_pulse"}, 32'(switch_pulse), 32'd1);
    chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_id", 32'(warp_id), 32'd0);
    chk("rst_pc", 32'(current_pc), 32'd0);
    chk("rst_pulse", 32'(switch_pulse), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk("sel0_valid", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("first", 2'd0, 8'h00);
    reset = 1'b0;
    #1;
    chk("midrst_valid", 32'(grant_valid), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    reset = 1'b1;
    tick();
    chk("sel1_valid", 32'(grant_valid), 32'd0);
    chk("sel1_grant", 32'(grant), 32'd0);
    tick();
    chk_grant("relaunch", 2'd0, 8'h00);
    pc_update_valid = 1'b1;
    pc_update = 8'h12;
    tick();
    chk("w0_upd", 32'(current_pc), 32'h12);
    pc_update_valid = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    chk_switch("sw0");
    stall = 1'b0;
    tick();
    chk_grant("w1", 2'd1, 8'h00);
    chk("w1_pulse", 32'(switch_pulse), 32'd0);
    pc_update_valid = 1'b1;
    pc_update = 8'h40;
    tick();
    chk("w1_upd", 32'(current_pc), 32'h40);
    pc_update_valid = 1'b0;
    stall = 1'b1;
    tick();
    chk_switch("sw1");
    stall = 1'b0;
    tick();
    chk_grant("w2", 2'd2, 8'h00);
    stall = 1'b1;
    tick();
    chk("minrun_valid", 32'(grant_valid), 32'd1);
    chk("minrun_pulse", 32'(switch_pulse), 32'd0);
    chk("minrun_id", 32'(warp_id), 32'd2);
    tick();
    chk_switch("sw2");
    stall = 1'b0;
    tick();
    chk_grant("w3", 2'd3, 8'h00);
    stall = 1'b1;
    tick();
    tick();
    chk_switch("sw3");
    stall = 1'b0;
    tick();
    chk_grant("w0_back", 2'd0, 8'h12);
    stall = 1'b1;
    tick();
    tick();
    chk_switch("sw4");
    stall = 1'b0;
    tick();
    chk_grant("w1_back", 2'd1, 8'h40);
    ret = 1'b1;
    stall = 1'b1;
    tick();
    chk("retstall_pulse", 32'(switch_pulse), 32'd0);
    chk("retstall_valid", 32'(grant_valid), 32'd0);
    ret = 1'b0;
    stall = 1'b0;
    tick();
    chk_grant("after_ret", 2'd2, 8'h00);
    reset = 1'b0;
    warp_count = 3'd3;
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk_grant("r_w0", 2'd0, 8'h00);
    stall = 1'b1;
    tick();
    tick();
    chk_switch("r_sw0");
    stall = 1'b0;
    tick();
    chk_grant("r_w1", 2'd1, 8'h00);
    ret = 1'b1;
    tick();
    chk("r_ret1_valid", 32'(grant_valid), 32'd0);
    chk("r_ret1_done", 32'(done), 32'd0);
    ret = 1'b0;
    tick();
    chk_grant("r_w2", 2'd2, 8'h00);
    stall = 1'b1;
    tick();
    tick();
    chk_switch("r_sw2");
    stall = 1'b0;
    tick();
    chk_grant("r_w0b", 2'd0, 8'h00);
    ret = 1'b1;
    tick();
    chk("r_ret0_valid", 32'(grant_valid), 32'd0);
    ret = 1'b0;
    tick();
    chk_grant("r_w2b", 2'd2, 8'h00);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sole_valid", 32'(grant_valid), 32'd1);
      chk("sole_pulse", 32'(switch_pulse), 32'd0);
    end
    stall = 1'b0;
    ret = 1'b1;
    tick();
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_valid", 32'(grant_valid), 32'd0);
    ret = 1'b0;
    tick();
    chk("fin_hold", 32'(done), 32'd1);
    start = 1'b0;
    tick();
    chk("fin_clear", 32'(done), 32'd0);
    tick();
    chk("idle_valid", 32'(grant_valid), 32'd0);
    warp_count = 3'd0;
    start = 1'b1;
    tick();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_valid", 32'(grant_valid), 32'd0);
    tick();
    chk("zero_grant", 32'(grant), 32'd0);
    start = 1'b0;
    tick();
    chk("zero_clear", 32'(done), 32'd0);
    warp_count = 3'd1;
    start = 1'b1;
    stall = 1'b1;
    tick();
    chk("one_sel", 32'(grant_valid), 32'd0);
    tick();
    chk_grant("one_w0", 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("one_valid", 32'(grant_valid), 32'd1);
      chk("one_pulse", 32'(switch_pulse), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/warp_arbiter.md
Name: warp_arbiter

Overview:
- Sequences a single compute core's shared fetch/decode/execute datapath between NUM_WARPS resident warps.
- Holds a per-warp PC context and a per-warp done bit, and grants exactly one warp at a time.
- Switches warps round-robin when the granted warp stalls on fetch or LSU, or retires (RET).
- Sits between the dispatcher (start/done) and the core's scheduler, which consumes grant, warp_id and current_pc.

Parameters:
- NUM_WARPS, 4, number of warp contexts (>=2).
- PC_BITS, 8, program counter width.
- MIN_RUN, 2, minimum granted cycles before a stall may cause a switch (anti-ping-pong, >=1).
- WID_BITS, $clog2(NUM_WARPS), warp index width.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  dispatcher launch; level, held until done seen.
- warp_count  input  WID_BITS+1  number of active warps for this block (0..NUM_WARPS).
- stall  input  1  granted warp waiting on fetcher or any LSU this cycle.
- ret  input  1  granted warp executed RET (single-cycle pulse).
- pc_update_valid  input  1  scheduler is writing the granted warp's next PC.
- pc_update  input  PC_BITS  next PC value.
- grant  output  NUM_WARPS  one-hot grant, all-zero when grant_valid=0.
- grant_valid  output  1  a warp owns the datapath.
- warp_id  output  WID_BITS  index of granted warp (holds last value when not valid).
- current_pc  output  PC_BITS  PC of granted warp.
- switch_pulse  output  1  one-cycle pulse on a stall-induced switch.
- done  output  1  all active warps retired.

Behaviour:
- Reset (reset=0, async) forces: state IDLE; grant=0, grant_valid=0, warp_id=0, current_pc=0, switch_pulse=0, done=0; all pc contexts=0; done bits=0; rr pointer=0; run counter=0. Reset mid-operation aborts immediately; there is no drain.
- All outputs are registered. start is ignored outside IDLE.
- IDLE:
  - On start=1 with warp_count=0: go to DONE.
  - On start=1 otherwise: clear pc contexts; set done bit for each warp index >= warp_count, clear the rest; rr=0; go to SELECT.
- SELECT (one cycle, grant_valid=0):
  - Choose the first not-done warp scanning rr, rr+1, ... with wrap modulo NUM_WARPS.
  - Next cycle: grant_valid=1, grant one-hot, warp_id, current_pc=pc[warp]; run counter=1; go to RUN.
- RUN, evaluated with priority ret > stall > pc_update:
  - ret=1:
    - Set the warp's done bit; drop grant_valid.
    - If every other warp is done, go to DONE; else rr=warp+1 (wrapped) and go to SELECT.
    - A pc_update in the same cycle is still written but is irrelevant.
  - stall=1, run counter >= MIN_RUN, and at least one other not-done warp exists:
    - Drop grant_valid; switch_pulse=1 for one cycle; rr=warp+1 (wrapped); go to SELECT.
    - The stalled warp's pc context is retained unchanged.
  - stall=1 with no other eligible warp, or run counter < MIN_RUN: stay granted; no pulse.
  - pc_update_valid=1 without ret: pc[warp] and current_pc <= pc_update, visible the next cycle.
  - Run counter saturates at MIN_RUN.
- Switch latency: stall sampled at cycle N; grant_valid=0 at N+1; new warp granted at N+2.
- DONE: done=1, grant_valid=0. When start=0, go to IDLE and done=0 on the next edge.
- Invariants:
  - grant is one-hot or zero.
  - grant_valid=1 implies the granted warp's done bit is 0.
  - A warp is never re-granted after its ret until the next launch.

Test Plan:
- Reset/launch: reset low mid-RUN with warp_count=4, then release; start=1 -> all outputs 0; SELECT one cycle; warp 0 granted with current_pc=0 two cycles after start.
- Round-robin on stall: NUM_WARPS=4, warp_count=4, warp 0 runs 3 cycles then stall=1 -> switch_pulse at N+1, warp 1 granted at N+2; repeated stalls -> order 1,2,3,0.
- PC context save/restore: warp 0 pc_update 0x12 then stalls; warp 1 pc_update 0x40 then stalls -> warp 0 regranted later with current_pc=0x12; warp 1 next granted with current_pc=0x40.
- MIN_RUN/sole warp: stall asserted on the first granted cycle -> no switch until run counter reaches 2; warp_count=1 with stall held -> grant never drops, switch_pulse stays 0.
- Retirement: warp_count=3; ret on warps 1, 0, 2 in turn -> each retired warp is skipped on later SELECTs; after the final ret, done=1 the next cycle; start=0 -> done=0, IDLE.
- Edge cases: warp_count=0 with start -> DONE, no grant ever asserted; ret and stall in the same cycle -> treated as ret, no switch_pulse.
